// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared clear-FSM encoding and byte-merge helper for the register file.
package regfile_mp_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} clr_state_t;
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
        return en ? new_b : old_b;
    endfunction
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: soft-clear sequencer sweeping r1..r(DEPTH-1), one register per cycle.
module regfile_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          clr_req,
    output logic          wr_stall,
    output logic          clr_done,
    output logic          idle,
    output logic          clr_stb,
    output logic [AW-1:0] clr_idx
);
    localparam logic [AW-1:0] LAST = '1;
    clr_state_t    r_state;
    clr_state_t    w_next;
    logic [AW-1:0] r_ptr;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
            r_ptr   <= AW'(1);
        end else begin
            r_state <= w_next;
            r_ptr   <= (r_state == ST_SWEEP) ? r_ptr + AW'(1) : AW'(1);
        end
    end
    always_comb begin
        w_next = ST_IDLE;
        w_next = (r_state == ST_IDLE)  ? (clr_req ? ST_SWEEP : ST_IDLE) :
                 (r_state == ST_SWEEP) ? ((r_ptr == LAST) ? ST_DONE : ST_SWEEP) : ST_IDLE;
    end
    assign wr_stall = (r_state == ST_SWEEP);
    assign clr_stb  = (r_state == ST_SWEEP);
    assign clr_done = (r_state == ST_DONE);
    assign idle     = (r_state == ST_IDLE);
    assign clr_idx  = r_ptr;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2R/1W register file with byte enables, optional write bypass,
// busy scoreboard and sequenced soft clear; r0 reads as zero.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [AW-1:0]   rna,
    input  logic [AW-1:0]   rnb,
    output logic [DW-1:0]   qa,
    output logic [DW-1:0]   qb,
    input  logic [AW-1:0]   wn,
    input  logic [DW-1:0]   d,
    input  logic            we,
    input  logic [DW/8-1:0] wbe,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rn,
    output logic            busya,
    output logic            busyb,
    input  logic            clr_req,
    output logic            wr_stall,
    output logic            clr_done
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;
    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DW-1:0]    w_wdata;
    logic [DW-1:0]    w_qa;
    logic [DW-1:0]    w_qb;
    logic             w_idle;
    logic             w_clr;
    logic [AW-1:0]    w_clr_idx;
    logic             w_wacc;
    logic             w_iss;

    regfile_clr_seq #(.AW(AW)) u_clr (
        .clk      (clk),
        .clrn     (clrn),
        .clr_req  (clr_req),
        .wr_stall (wr_stall),
        .clr_done (clr_done),
        .idle     (w_idle),
        .clr_stb  (w_clr),
        .clr_idx  (w_clr_idx)
    );

    assign w_wacc = we && (wn != '0) && w_idle;
    assign w_iss  = iss_valid && (iss_rn != '0) && w_idle;

    // Merged word is both the next stored value and the bypass data.
    for (genvar b = 0; b < NB; b++) begin : g_merge
        assign w_wdata[8*b +: 8] = byte_merge(r_mem[wn][8*b +: 8], d[8*b +: 8], wbe[b]);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_clr) begin
                r_mem[w_clr_idx]  <= '0;
                r_busy[w_clr_idx] <= 1'b0;
            end
            if (w_wacc) begin
                r_mem[wn]  <= w_wdata;
                r_busy[wn] <= 1'b0;
            end
            if (w_iss) r_busy[iss_rn] <= 1'b1;
        end
    end

    assign w_qa  = (rna == '0) ? '0 : r_mem[rna];
    assign w_qb  = (rnb == '0) ? '0 : r_mem[rnb];
    assign qa    = ((BYPASS != 0) && w_wacc && (wn == rna) && (rna != '0)) ? w_wdata : w_qa;
    assign qb    = ((BYPASS != 0) && w_wacc && (wn == rnb) && (rnb != '0)) ? w_wdata : w_qb;
    assign busya = r_busy[rna];
    assign busyb = r_busy[rnb];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus checked against a cycle-level reference model.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic [AW-1:0] rna = '0, rnb = '0, wn = '0, iss_rn = '0;
    logic [DW-1:0] d = '0;
    logic we = 1'b0, iss_valid = 1'b0, clr_req = 1'b0;
    logic [3:0] wbe = '0;
    logic [DW-1:0] qa, qb, qa0, qb0;
    logic busya, busyb, wr_stall, clr_done;
    logic busya0, busyb0, wr_stall0, clr_done0;

    logic [DW-1:0] m_mem [DEPTH];
    logic m_busy [DEPTH];
    int sw_cnt, n_chk, n_fail, cyc, stall_cyc, done_cnt, done_at;
    bit dn;

    always #5 clk = ~clk;

    regfile_mp #(.DW(DW), .AW(AW), .BYPASS(1)) u_dut (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .wn(wn), .d(d), .we(we), .wbe(wbe), .iss_valid(iss_valid), .iss_rn(iss_rn),
        .busya(busya), .busyb(busyb), .clr_req(clr_req), .wr_stall(wr_stall), .clr_done(clr_done)
    );

    regfile_mp #(.DW(DW), .AW(AW), .BYPASS(0)) u_nb (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
        .wn(wn), .d(d), .we(we), .wbe(wbe), .iss_valid(iss_valid), .iss_rn(iss_rn),
        .busya(busya0), .busyb(busyb0), .clr_req(clr_req), .wr_stall(wr_stall0), .clr_done(clr_done0)
    );

    function automatic logic [DW-1:0] merged(input logic [DW-1:0] old);
        logic [DW-1:0] v = old;
        for (int b = 0; b < 4; b++) if (wbe[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic bit acc();
        return we && (wn != 0) && (sw_cnt == 0) && !dn;
    endfunction

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] rn, input bit byp);
        if (rn == 0) return '0;
        if (byp && acc() && wn == rn) return merged(m_mem[rn]);
        return m_mem[rn];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        sw_cnt = 0;
        dn = 1'b0;
    endtask

    task automatic quiet();
        we = 1'b0;
        iss_valid = 1'b0;
        clr_req = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit a;
        int idx;
        #1;
        if (!clrn) model_reset();
        chk("qa", qa, rd(rna, 1));
        chk("qb", qb, rd(rnb, 1));
        chk("qa_nobyp", qa0, rd(rna, 0));
        chk("qb_nobyp", qb0, rd(rnb, 0));
        chk("busya", busya, m_busy[rna]);
        chk("busyb", busyb, m_busy[rnb]);
        chk("wr_stall", wr_stall, sw_cnt > 0);
        chk("clr_done", clr_done, dn);
        stall_cyc += int'(wr_stall);
        if (clr_done) begin
            done_cnt++;
            done_at = cyc;
        end
        a = acc();
        @(posedge clk);
        if (clrn) begin
            if (sw_cnt > 0) begin
                idx = DEPTH - sw_cnt;
                m_mem[idx] = '0;
                m_busy[idx] = 1'b0;
                sw_cnt--;
                dn = (sw_cnt == 0);
            end else if (dn) begin
                dn = 1'b0;
            end else begin
                if (a) begin
                    m_mem[wn] = merged(m_mem[wn]);
                    m_busy[wn] = 1'b0;
                end
                if (iss_valid && iss_rn != 0) m_busy[iss_rn] = 1'b1;
                if (clr_req) sw_cnt = DEPTH - 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] n, input logic [DW-1:0] v, input logic [3:0] e);
        quiet();
        we = 1'b1; wn = n; d = v; wbe = e;
        step();
        quiet();
    endtask

    initial begin
        model_reset();
        n_chk = 0; n_fail = 0; cyc = 0; stall_cyc = 0; done_cnt = 0; done_at = -1;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        rna = 5; rnb = 31;
        #1;
        chk("rst_qa", qa, 0);
        chk("rst_qb", qb, 0);
        chk("rst_busy", {busya, busyb}, 0);
        chk("rst_stall", {wr_stall, clr_done}, 0);
        step();

        wr(5, 32'hDEADBEEF, 4'hF);
        rna = 5; #1;
        chk("wr_r5", qa, 32'hDEADBEEF);
        step();
        wr(0, 32'h1, 4'hF);
        rna = 0; #1;
        chk("r0_zero", qa, 0);
        step();

        we = 1'b1; wn = 5; d = 32'h11223344; wbe = 4'b0101; rna = 5; #1;
        chk("bypass", qa, 32'hDE22BE44);
        chk("nobypass", qa0, 32'hDEADBEEF);
        step();
        quiet(); #1;
        chk("merged_stored", qa, 32'hDE22BE44);
        step();

        iss_valid = 1'b1; iss_rn = 7; rna = 7; step();
        quiet(); #1;
        chk("busy_set", busya, 1);
        step();
        we = 1'b1; wn = 7; d = 32'h77; wbe = 4'hF; iss_valid = 1'b1; iss_rn = 7; step();
        quiet(); #1;
        chk("busy_set_wins", busya, 1);
        step();
        wr(7, 32'h78, 4'h0);
        #1;
        chk("busy_clr", busya, 0);
        chk("wbe0_hold", qa, 32'h77);
        step();

        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom); wn = AW'($urandom); d = $urandom; wbe = 4'($urandom);
            iss_valid = 1'($urandom); iss_rn = AW'($urandom);
            rna = AW'($urandom); rnb = (i % 4 == 0) ? wn : AW'($urandom);
            clr_req = ($urandom_range(0, 49) == 0);
            step();
        end
        quiet();
        for (int i = 0; i < 40; i++) step();

        for (int i = 1; i < DEPTH; i++) begin
            iss_valid = 1'b1; iss_rn = AW'(i);
            we = 1'b1; wn = AW'(i); d = 32'hA5000000 | i; wbe = 4'hF;
            step();
        end
        quiet();
        stall_cyc = 0; done_cnt = 0; done_at = -1; cyc = 0;
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        for (int k = 1; k < 40; k++) begin
            we = (k == 20); wn = 3; d = 32'hBAD0BAD0; wbe = 4'hF;
            clr_req = (k == 10);
            rna = AW'(k); rnb = 31;
            step();
        end
        quiet();
        chk("stall_len", stall_cyc, 31);
        chk("done_cnt", done_cnt, 1);
        chk("done_at", done_at, 32);
        for (int i = 0; i < DEPTH; i++) begin
            rna = AW'(i); #1;
            chk("swept_zero", qa, 0);
            chk("swept_busy", busya, 0);
        end
        step();

        wr(31, 32'hFFFFFFFF, 4'hF);
        rna = 31; #1;
        chk("r31_set", qa, 32'hFFFFFFFF);
        clrn = 1'b0; #1;
        model_reset();
        chk("r31_async_rst", qa, 0);
        step();
        clrn = 1'b1;
        step();

        stall_cyc = 0; done_cnt = 0;
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) step();
        clrn = 1'b0; #1;
        chk("stall_async_drop", wr_stall, 0);
        step();
        clrn = 1'b1;
        for (int k = 0; k < 40; k++) step();
        chk("no_done_after_rst", done_cnt, 0);
        chk("stall_before_rst", stall_cyc, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
